// File: rtl/nor_stimulus_checker_pkg.sv
// Shared definitions for the NOR gate stimulus checker: FSM state encoding,
// counter/index widths and the Gray-ordered {a,b} pattern table.
package nor_stimulus_checker_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned HOLD_W        = 8;
  localparam int unsigned PATTERN_COUNT = 4;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_DRIVE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  // {a,b} per pattern index; Gray order so only one input toggles per step
  localparam logic [1:0] PATTERN_TABLE [PATTERN_COUNT] = '{2'b00, 2'b01, 2'b11, 2'b10};

endpackage

// File: rtl/nor_stimulus_checker_if.sv
// Bundle between the stimulus checker and its surroundings.
//   start        : run request
//   y            : output of the NOR gate under check
//   a, b         : stimulus to the gate
//   busy, done   : run status
//   pass         : done with zero errors
//   err_count    : mismatch count of current/last run
//   pattern_idx  : pattern currently driven
interface nor_stimulus_checker_if
  import nor_stimulus_checker_pkg::*;
#(
  parameter int unsigned ERR_W = 4
);

  logic             start;
  logic             y;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] pattern_idx;

  // Environment side: requests runs, closes the loop through the gate
  modport master (
    output start, y,
    input  a, b, busy, done, pass, err_count, pattern_idx
  );

  // Checker side
  modport slave (
    input  start, y,
    output a, b, busy, done, pass, err_count, pattern_idx
  );

endinterface

// File: rtl/nor_hold_counter.sv
// Counts the cycles a pattern has been held and flags the last one.
//   clk, rst_n : clock, async active-low reset
//   clear      : force count to zero
//   enable     : advance the count this cycle
//   wrap_c     : high during the final hold cycle (count == HOLD_CYCLES-1)
module nor_hold_counter
  import nor_stimulus_checker_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic wrap_c
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q;

  assign wrap_c = enable && (cnt_q == LAST);

  // Hold counter, wraps to zero on the sampling cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || wrap_c) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/nor_stimulus_checker.sv
// Drives the four {a,b} patterns onto an external 2-input NOR gate, holds each
// for HOLD_CYCLES cycles, samples the gate output on the last cycle of each
// hold and counts mismatches.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of nor_stimulus_checker_if (start/y in,
//                a/b/busy/done/pass/err_count/pattern_idx out, all registered)
module nor_stimulus_checker
  import nor_stimulus_checker_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nor_stimulus_checker_if.slave bus
);

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_COUNT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               hold_en_c;
  logic               hold_clear_c;
  logic               wrap_c;
  logic               mismatch_c;

  assign hold_en_c    = (state_q == ST_DRIVE);
  assign hold_clear_c = !hold_en_c;

  nor_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (hold_clear_c),
    .enable (hold_en_c),
    .wrap_c (wrap_c)
  );

  // Mismatch unless y provably equals the NOR of the driven inputs, so an
  // unknown y falls into the mismatch branch.
  always_comb begin
    mismatch_c = 1'b1;
    if (bus.y == ~(a_q | b_q)) begin
      mismatch_c = 1'b0;
    end
  end

  // State and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_DRIVE: begin
        // start is deliberately ignored here
        if (wrap_c) begin
          if (mismatch_c && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            {a_d, b_d} = PATTERN_TABLE[idx_d];
          end
        end
      end

      // IDLE and DONE both launch a fresh run on start
      default: begin
        if (bus.start) begin
          state_d    = ST_DRIVE;
          idx_d      = '0;
          err_d      = '0;
          {a_d, b_d} = PATTERN_TABLE[0];
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
    endcase
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.err_count   = err_q;
  assign bus.pattern_idx = idx_q;

endmodule

// File: doc/nor_stimulus_checker.md
NOR_STIMULUS_CHECKER -- requirements
Module: nor_stimulus_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: clock cycles each input pattern is held on a/b; legal range 2..255.
REQ-002 Parameter ERR_W, default 4: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  run request, sampled on the rising edge of clk.
REQ-006 y  input  1  output of the 2-input NOR gate under check, combinational from a/b.
REQ-007 a  output  1  stimulus to gate input A, registered.
REQ-008 b  output  1  stimulus to gate input B, registered.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next accepted start or reset.
REQ-011 pass  output  1  high only when done=1 and err_count=0.
REQ-012 err_count  output  ERR_W  number of mismatching samples in the current or last run.
REQ-013 pattern_idx  output  2  index of the pattern currently driven, 0..3.

Function
REQ-014 The block SHALL drive the patterns {a,b} in this fixed Gray order: idx0=00, idx1=01, idx2=11, idx3=10.
REQ-015 The FSM SHALL have these states: IDLE, DRIVE, DONE.
REQ-016 IDLE: a=b=0, busy=0, done=0; start=1 at edge k SHALL move the FSM to DRIVE with idx=0, hold_cnt=0, err_count=0.
REQ-017 DRIVE: hold_cnt SHALL increment each cycle; each pattern is held exactly HOLD_CYCLES cycles.
REQ-018 At the edge where hold_cnt=HOLD_CYCLES-1, the block SHALL sample y and compare it with expected = ~(a|b).
REQ-019 On a mismatch, err_count SHALL increment by 1 and saturate at 2^ERR_W-1.
REQ-020 At the same edge, hold_cnt SHALL clear and idx SHALL advance; after idx3 is sampled, the FSM SHALL go to DONE.
REQ-021 Latency: done SHALL rise at edge k+4*HOLD_CYCLES, where k is the start edge; busy SHALL be high for exactly 4*HOLD_CYCLES cycles.
REQ-022 DONE: a=b=0, busy=0, done=1, and err_count SHALL be frozen.
REQ-023 start=1 while in DONE SHALL restart a run exactly as from IDLE, with done falling on the same edge.
REQ-024 start SHALL be ignored while busy=1 and SHALL NOT disturb the run in progress.
REQ-025 start held high continuously SHALL produce back-to-back runs, each restarted from DONE.
REQ-026 X or Z on y SHALL count as a mismatch.
REQ-027 pattern_idx SHALL read 0 in IDLE and DONE.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, idx=0, hold_cnt=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-030 After rst_n rises, the block SHALL remain in IDLE until start is seen at a clock edge.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit) and the 4-entry pattern table.
REQ-032 One sub-module, nor_hold_counter, SHALL implement the hold counter, taking clk, rst_n, clear and enable and outputting a wrap pulse.
REQ-033 No other hierarchy SHALL be used; the NOR gate itself is instantiated outside this block, alongside it.

Verification
REQ-034 Correct NOR gate connected, HOLD_CYCLES=4, start pulsed at edge k -> a/b sequence 00,01,11,10 with 4 cycles each; done=1 at k+16; pass=1; err_count=0.
REQ-035 y tied to 0 -> err_count=1 (pattern 00 mismatches), pass=0; y tied to 1 -> err_count=3.
REQ-036 y driven as a|b (OR gate), ERR_W=2 -> all 4 samples mismatch; err_count saturates at 3.
REQ-037 start re-pulsed at cycle 5 of a run -> no effect; done still at k+16 with unchanged results.
REQ-038 rst_n pulled low between clock edges during idx2 -> outputs clear immediately; a fresh start gives a full 16-cycle run with pass=1.
REQ-039 start held high continuously -> done high for one cycle every 17 cycles; err_count clears at each restart.
